// File: rtl/pc_pkg.sv
// Shared types and default vectors for the fetch-stage program counter unit.
package pc_pkg;

    typedef enum logic [2:0] {
        SEL_SEQ,
        SEL_RET,
        SEL_REDIR,
        SEL_EXC,
        SEL_HOLD
    } next_sel_t;

    localparam logic [31:0] DEF_RESET_VECTOR = 32'h0000_0000;
    localparam logic [31:0] DEF_EXC_VECTOR   = 32'h0000_0180;

endpackage

// File: rtl/pc_unit_if.sv
// Control and status bundle between decode/branch logic (master) and pc_unit (slave).
// Inputs are sampled at rising clk with no handshake; the master holds them stable at the edge.
interface pc_unit_if #(
    parameter int WIDTH     = 32,
    parameter int RAS_DEPTH = 4
) ();
    localparam int CW = $clog2(RAS_DEPTH) + 1;

    logic                  stall;
    logic                  exc_req;
    logic                  redirect_valid;
    logic [WIDTH-1:0]      redirect_target;
    logic                  call;
    logic                  ret;
    logic [WIDTH-1:0]      pc;
    logic [CW-1:0]         ras_count;
    logic                  ras_empty;
    logic                  ras_full;
    logic                  ret_underflow;
    pc_pkg::next_sel_t     sel_dbg;

    modport master (
        output stall, exc_req, redirect_valid, redirect_target, call, ret,
        input  pc, ras_count, ras_empty, ras_full, ret_underflow, sel_dbg
    );

    modport slave (
        input  stall, exc_req, redirect_valid, redirect_target, call, ret,
        output pc, ras_count, ras_empty, ras_full, ret_underflow, sel_dbg
    );

endinterface

// File: rtl/ras_stack.sv
// Circular return-address stack: pushes past capacity overwrite the oldest entry,
// and a simultaneous push/pop replaces the top entry in place.
module ras_stack #(
    parameter int WIDTH     = 32,
    parameter int RAS_DEPTH = 4
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           push,
    input  logic                           pop,
    input  logic                           clear,
    input  logic [WIDTH-1:0]               push_data,
    output logic [WIDTH-1:0]               top_data,
    output logic [$clog2(RAS_DEPTH):0]     count
);
    localparam int PW = $clog2(RAS_DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] mem_q [RAS_DEPTH];
    logic [PW-1:0]    top_q, top_d, wr_idx;
    logic [CW-1:0]    count_q, count_d;
    logic             wr_en;

    always_comb begin
        top_d   = top_q;
        count_d = count_q;
        wr_en   = 1'b0;
        wr_idx  = top_q;
        if (clear) begin
            top_d   = '0;
            count_d = '0;
        end else if (push && pop) begin
            // The ret target is read before the edge; the same slot takes the new link.
            wr_en = 1'b1;
            if (count_q == '0) begin
                count_d = CW'(1);
            end
        end else if (push) begin
            wr_en  = 1'b1;
            wr_idx = top_q + PW'(1);
            top_d  = top_q + PW'(1);
            if (count_q != CW'(RAS_DEPTH)) begin
                count_d = count_q + CW'(1);
            end
        end else if (pop && (count_q != '0)) begin
            top_d   = top_q - PW'(1);
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            top_q   <= '0;
            count_q <= '0;
        end else begin
            top_q   <= top_d;
            count_q <= count_d;
        end
    end

    // Entry contents are don't-care after reset, so the array carries no reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_idx] <= push_data;
        end
    end

    assign top_data = mem_q[top_q];
    assign count    = count_q;

endmodule

// File: rtl/pc_unit.sv
// Fetch-stage program counter with stall, redirect, exception and a return-address stack.
// Priority: exception, stall, redirect, ret with a non-empty stack, sequential.
module pc_unit
    import pc_pkg::*;
#(
    parameter int               WIDTH        = 32,
    parameter logic [WIDTH-1:0] RESET_VECTOR = WIDTH'(DEF_RESET_VECTOR),
    parameter logic [WIDTH-1:0] EXC_VECTOR   = WIDTH'(DEF_EXC_VECTOR),
    parameter int               INC          = 4,
    parameter int               RAS_DEPTH    = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    pc_unit_if.slave   bus
);
    localparam int CW = $clog2(RAS_DEPTH) + 1;

    logic [WIDTH-1:0] pc_q, pc_d, pc_inc, ras_top;
    logic             underflow_q, underflow_d;
    logic [CW-1:0]    ras_count;
    logic             ras_empty;
    logic             ras_push, ras_pop, ras_clear;
    next_sel_t        sel;

    assign pc_inc    = pc_q + WIDTH'(INC);
    assign ras_empty = (ras_count == '0);

    always_comb begin
        sel         = SEL_SEQ;
        ras_push    = 1'b0;
        ras_pop     = 1'b0;
        ras_clear   = 1'b0;
        underflow_d = 1'b0;
        if (bus.exc_req) begin
            sel       = SEL_EXC;
            ras_clear = 1'b1;
        end else if (bus.stall) begin
            sel = SEL_HOLD;
        end else begin
            ras_push = bus.call;
            // A ret is honoured even under a redirect; only its target is dropped.
            ras_pop     = bus.ret;
            underflow_d = bus.ret && ras_empty;
            if (bus.redirect_valid) begin
                sel = SEL_REDIR;
            end else if (bus.ret && !ras_empty) begin
                sel = SEL_RET;
            end
        end
    end

    always_comb begin
        pc_d = pc_inc;
        unique case (sel)
            SEL_EXC:   pc_d = EXC_VECTOR;
            SEL_HOLD:  pc_d = pc_q;
            SEL_REDIR: pc_d = bus.redirect_target;
            SEL_RET:   pc_d = ras_top;
            default:   pc_d = pc_inc;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q        <= RESET_VECTOR;
            underflow_q <= 1'b0;
        end else begin
            pc_q        <= pc_d;
            underflow_q <= underflow_d;
        end
    end

    ras_stack #(
        .WIDTH     (WIDTH),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (ras_push),
        .pop       (ras_pop),
        .clear     (ras_clear),
        .push_data (pc_inc),
        .top_data  (ras_top),
        .count     (ras_count)
    );

    assign bus.pc            = pc_q;
    assign bus.ras_count     = ras_count;
    assign bus.ras_empty     = ras_empty;
    assign bus.ras_full      = (ras_count == CW'(RAS_DEPTH));
    assign bus.ret_underflow = underflow_q;
    assign bus.sel_dbg       = sel;

endmodule

// File: tb/tb_pc_unit.sv
// Directed bench for pc_unit: each step drives controls, waits one edge, and checks
// the registered outputs against hand-computed values.
module tb_pc_unit;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    pc_unit_if #(.WIDTH(32), .RAS_DEPTH(4)) bus_if ();

    pc_unit #(
        .WIDTH        (32),
        .RESET_VECTOR (32'h0000_0000),
        .EXC_VECTOR   (32'h0000_0180),
        .INC          (4),
        .RAS_DEPTH    (4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic st, input logic exc, input logic rv,
                         input logic [31:0] tgt, input logic cl, input logic rt);
        bus_if.stall           = st;
        bus_if.exc_req         = exc;
        bus_if.redirect_valid  = rv;
        bus_if.redirect_target = tgt;
        bus_if.call            = cl;
        bus_if.ret             = rt;
    endtask

    // Apply controls, then sample 1 ns after the next rising edge.
    task automatic step(input logic st, input logic exc, input logic rv,
                        input logic [31:0] tgt, input logic cl, input logic rt);
        drive(st, exc, rv, tgt, cl, rt);
        @(posedge clk);
        #1;
    endtask

    task automatic chk_state(input string tag, input logic [31:0] pc_e,
                             input logic [31:0] cnt_e, input logic uf_e);
        chk({tag, ".pc"}, bus_if.pc, pc_e);
        chk({tag, ".cnt"}, 32'(bus_if.ras_count), cnt_e);
        chk({tag, ".uf"}, 32'(bus_if.ret_underflow), 32'(uf_e));
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        #12;
        chk_state("reset", 32'h0, 32'd0, 1'b0);
        chk("reset.empty", 32'(bus_if.ras_empty), 32'd1);
        chk("reset.full", 32'(bus_if.ras_full), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Sequential fetch after reset release.
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        chk("idle1", bus_if.pc, 32'h4);
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        chk("idle2", bus_if.pc, 32'h8);
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        chk("idle3", bus_if.pc, 32'hC);

        // Asynchronous reset mid-stream takes effect without an edge.
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst", bus_if.pc, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Jump-and-link then return.
        step(1'b0, 1'b0, 1'b1, 32'h100, 1'b0, 1'b0);
        chk("redir", bus_if.pc, 32'h100);
        step(1'b0, 1'b0, 1'b1, 32'h400, 1'b1, 1'b0);
        chk_state("jal", 32'h400, 32'd1, 1'b0);
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        chk("after_jal", bus_if.pc, 32'h404);
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        chk_state("ret1", 32'h104, 32'd0, 1'b0);
        chk("ret1.empty", 32'(bus_if.ras_empty), 32'd1);

        // Five links into a four-deep stack: oldest (0x14) is overwritten.
        step(1'b0, 1'b0, 1'b1, 32'h10, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 32'h20, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b1, 32'h30, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b1, 32'h40, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b1, 32'h50, 1'b1, 1'b0);
        chk("call4.cnt", 32'(bus_if.ras_count), 32'd4);
        step(1'b0, 1'b0, 1'b1, 32'h60, 1'b1, 1'b0);
        chk_state("call5", 32'h60, 32'd4, 1'b0);
        chk("call5.full", 32'(bus_if.ras_full), 32'd1);
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        chk_state("pop1", 32'h54, 32'd3, 1'b0);
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        chk_state("pop2", 32'h44, 32'd2, 1'b0);
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        chk_state("pop3", 32'h34, 32'd1, 1'b0);
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        chk_state("pop4", 32'h24, 32'd0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        chk_state("pop5_underflow", 32'h28, 32'd0, 1'b1);
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        chk_state("uf_pulse_end", 32'h2C, 32'd0, 1'b0);

        // Plain call, then stall ignores call/ret/redirect.
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        chk_state("call_plain", 32'h30, 32'd1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b0, 1'b1, 32'h999, 1'b1, 1'b1);
            chk_state($sformatf("stall%0d", i), 32'h30, 32'd1, 1'b0);
        end
        step(1'b1, 1'b1, 1'b1, 32'h999, 1'b1, 1'b1);
        chk_state("exc_in_stall", 32'h180, 32'd0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        chk("after_exc", bus_if.pc, 32'h184);

        // call+ret at 0x200 with top 0x80: top replaced by 0x204.
        step(1'b0, 1'b0, 1'b1, 32'h7C, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 32'h200, 1'b1, 1'b0);
        chk_state("setup_top80", 32'h200, 32'd1, 1'b0);
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
        chk_state("call_ret", 32'h80, 32'd1, 1'b0);
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        chk_state("ret_replaced", 32'h204, 32'd0, 1'b0);

        // call+ret on an empty stack: count becomes 1 and underflow pulses.
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
        chk_state("call_ret_empty", 32'h208, 32'd1, 1'b1);
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        chk_state("ret_after_cr", 32'h208, 32'd0, 1'b0);

        // ret under a redirect: redirect wins, stack still pops.
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        chk_state("call_20c", 32'h20C, 32'd1, 1'b0);
        step(1'b0, 1'b0, 1'b1, 32'h300, 1'b0, 1'b1);
        chk_state("ret_redir", 32'h300, 32'd0, 1'b0);

        // Address wrap.
        step(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0);
        chk("wrap_setup", bus_if.pc, 32'hFFFF_FFFC);
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        chk("wrap", bus_if.pc, 32'h0000_0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pc_unit.md
# pc_unit

Parametrised program-counter unit for the processor fetch stage. It replaces the plain PC register with stall, redirect, and exception handling. It also contains a small circular return-address stack (RAS) so that `ret` can resolve its target without going through the ALU path. The unit drives instruction-memory address generation and receives control from the decode/branch logic.

## Interface
- `WIDTH`, 32, PC and address width in bits.
- `RESET_VECTOR`, 32'h0000_0000, PC value after reset.
- `EXC_VECTOR`, 32'h0000_0180, PC value loaded on an exception.
- `INC`, 4, sequential increment in bytes.
- `RAS_DEPTH`, 4, number of return-address entries; power of two, 2..16.

Ports:
- `clk` in 1: rising-edge clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `stall` in 1: hold PC and RAS state.
- `exc_req` in 1: exception; force PC to `EXC_VECTOR`.
- `redirect_valid` in 1: taken branch or jump.
- `redirect_target` in WIDTH: target for the redirect.
- `call` in 1: link; push `PC+INC` onto the RAS.
- `ret` in 1: return; pop the RAS top into PC.
- `pc` out WIDTH: current PC, registered.
- `ras_count` out $clog2(RAS_DEPTH)+1: valid entries.
- `ras_empty` out 1: `ras_count==0`.
- `ras_full` out 1: `ras_count==RAS_DEPTH`.
- `ret_underflow` out 1: registered one-cycle pulse when `ret` was accepted with an empty RAS.

## Operation
- **Reset (`rst_n`=0):**
  - `pc`=`RESET_VECTOR`.
  - `ras_count`=0, top pointer=0, `ret_underflow`=0.
  - RAS entries are don't-care.
- **Next-PC priority:**
  - `exc_req` → `EXC_VECTOR`.
  - else `stall` → hold.
  - else `redirect_valid` → `redirect_target`.
  - else `ret` with RAS non-empty → RAS top.
  - else `PC+INC`. This includes `ret` with an empty RAS, which also sets `ret_underflow` for one cycle.
- **Exception:** `exc_req` overrides `stall`, clears the RAS (`ras_count`=0), and ignores `call`/`ret`.
- **Stall:** when `stall`=1 and `exc_req`=0, PC, RAS, and pointers are unchanged. `call`/`ret`/`redirect_valid` are ignored, and `ret_underflow` is 0.
- **`call`** (not stalled): push `PC+INC` (current PC, pre-update).
  - `call` with `redirect_valid` is jump-and-link: PC←`redirect_target`, push `PC+INC`.
  - `call` without redirect is legal: push, PC←`PC+INC`.
- **`ret`** (not stalled, no redirect): pop; PC←popped value.
  - `ret` with `redirect_valid`: the redirect wins for PC, the RAS is still popped, and the popped value is discarded.
- **`call` and `ret` in the same cycle:** the top entry is read as the ret target and replaced with `PC+INC`. `ras_count` is unchanged, and if it was 0 it becomes 1 with `ret_underflow`=1.
- **Push when full:** overwrite the oldest entry (the circular pointer wraps); `ras_count` saturates at `RAS_DEPTH`.
- **Pop when empty:** pointer and count are unchanged.
- **Arithmetic:** `PC+INC` is computed modulo 2^WIDTH, so `'1`-3 wraps to 0 when `INC`=4. No alignment check; targets are used verbatim.

## Timing
- All outputs are registered, with one-cycle latency from the control inputs to `pc`.
- The RAS read is combinational from the top pointer. The write and pointer update happen on the same edge as the PC update.
- `ras_empty` and `ras_full` are combinational decodes of the registered `ras_count`.
- Reset assertion takes effect immediately and asynchronously, mid-stream included. After deassertion, the first rising edge produces `RESET_VECTOR+INC` unless a control input is active.
- All inputs are sampled only at rising `clk`, with no handshake. The upstream logic guarantees that the inputs are stable at the edge.

## Structure
- Package `pc_pkg`:
  - enum `next_sel_t` {`SEL_SEQ`, `SEL_RET`, `SEL_REDIR`, `SEL_EXC`, `SEL_HOLD`}.
  - default `RESET_VECTOR`/`EXC_VECTOR` constants.
- Sub-module `ras_stack` (parameters `WIDTH`, `RAS_DEPTH`):
  - inputs: `push`, `pop`, `clear`, `push_data`.
  - outputs: `top_data`, `count`.
  - behaviour: circular overwrite and replace-on-push-and-pop as above.
- `pc_unit` holds the priority mux, the PC register, and the underflow pulse.

## Test plan
- Reset, then 3 idle cycles → `pc`=0, 4, 8, C; assert `rst_n`=0 mid-run → `pc`=0 immediately.
- PC=0x100 with `call`+`redirect_valid`, target 0x400 → `pc`=0x400, `ras_count`=1. Later `ret` → `pc`=0x104, `ras_count`=0.
- 5 calls from 0x10, 0x20, 0x30, 0x40, 0x50 with `RAS_DEPTH`=4 → count stays 4. Pops return 0x54, 0x44, 0x34, 0x24; a 5th `ret` → `PC+4`, `ret_underflow`=1.
- `stall`=1 with `call`, `ret`, and a redirect asserted for 3 cycles → `pc` and `ras_count` are unchanged. `exc_req` during a stall → `pc`=0x180 and `ras_count`=0.
- `call`+`ret` together at PC=0x200 with top=0x80 → `pc`=0x80, the top becomes 0x204, and the count is unchanged.
- PC=0xFFFF_FFFC, idle → `pc`=0x0000_0000 (wrap).
